// File: rtl/skyline_area_checker_if.sv
// Stream and result handshake bundle between the skyline sketch stage, the checker and its sink.
// The master side drives the stream and RES_READY; the slave side is the checker.
interface skyline_area_checker_if;
  logic        IN_VALID;
  logic [5:0]  IN_DATA;
  logic        RES_READY;
  logic        RES_VALID;
  logic [11:0] AREA;
  logic [4:0]  NPTS;
  logic [4:0]  ERR;

  modport master (
    output IN_VALID, IN_DATA, RES_READY,
    input  RES_VALID, AREA, NPTS, ERR
  );

  modport slave (
    input  IN_VALID, IN_DATA, RES_READY,
    output RES_VALID, AREA, NPTS, ERR
  );
endinterface

// File: rtl/skyline_area_checker.sv
// Collects one serialized skyline frame (x,y pairs), checks it is well-formed and reports
// the covered area, the point count and error flags to a ready/valid sink.
module skyline_area_checker #(
  parameter int MAX_PTS = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  skyline_area_checker_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_Y, S_X, S_DONE} state_t;

  localparam logic [4:0] MAX_PTS_W = 5'(MAX_PTS);

  state_t      state;
  logic [5:0]  cur_x;
  logic [5:0]  prev_x;
  logic [5:0]  prev_y;
  logic [11:0] term;
  logic [11:0] area_acc;
  logic [4:0]  npts_cnt;
  logic        err_x;
  logic        err_y;
  logic        overrun;

  logic        res_valid_q;
  logic [11:0] area_q;
  logic [4:0]  npts_q;
  logic [4:0]  err_q;

  logic [5:0]  dx;
  logic [11:0] prod;
  logic        frame_end;
  logic        shape_err;

  // The area term for a new x is held in 'term' and only committed once its y arrives,
  // so a trailing x without a y never contributes area.
  assign dx        = bus.IN_DATA - prev_x;
  assign prod      = {6'd0, dx} * {6'd0, prev_y};
  assign frame_end = !bus.IN_VALID && (state == S_Y || state == S_X);
  assign shape_err = (state == S_Y) || (prev_y != 6'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      cur_x       <= '0;
      prev_x      <= '0;
      prev_y      <= '0;
      term        <= '0;
      area_acc    <= '0;
      npts_cnt    <= '0;
      err_x       <= 1'b0;
      err_y       <= 1'b0;
      overrun     <= 1'b0;
      res_valid_q <= 1'b0;
      area_q      <= '0;
      npts_q      <= '0;
      err_q       <= '0;
    end else if (frame_end) begin
      res_valid_q <= 1'b1;
      area_q      <= area_acc;
      npts_q      <= npts_cnt;
      err_q       <= {npts_cnt > MAX_PTS_W, overrun, shape_err, err_y, err_x};
      overrun     <= 1'b0;
      state       <= S_DONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.IN_VALID) begin
            cur_x    <= bus.IN_DATA;
            term     <= '0;
            area_acc <= '0;
            npts_cnt <= '0;
            err_x    <= 1'b0;
            err_y    <= 1'b0;
            state    <= S_Y;
          end
        end
        S_Y: begin
          if (bus.IN_VALID) begin
            if (npts_cnt != 5'd0 && bus.IN_DATA == prev_y)
              err_y <= 1'b1;
            area_acc <= area_acc + term;
            prev_x   <= cur_x;
            prev_y   <= bus.IN_DATA;
            if (npts_cnt != 5'd31)
              npts_cnt <= npts_cnt + 5'd1;
            state    <= S_X;
          end
        end
        S_X: begin
          if (bus.IN_VALID) begin
            if (bus.IN_DATA > prev_x) begin
              term <= prod;
            end else begin
              term  <= '0;
              err_x <= 1'b1;
            end
            cur_x <= bus.IN_DATA;
            state <= S_Y;
          end
        end
        S_DONE: begin
          // Words arriving while a result is held, including on the accepting edge, are lost.
          if (bus.IN_VALID)
            overrun <= 1'b1;
          if (bus.RES_READY) begin
            res_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.RES_VALID = res_valid_q;
  assign bus.AREA      = area_q;
  assign bus.NPTS      = npts_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_skyline_area_checker.sv
// Directed bench for skyline_area_checker: hand-computed frames covering area, error flags,
// point-count limits, backpressure, overrun and mid-frame reset.
module tb_skyline_area_checker;

  logic CLK;
  logic RESET;
  int   n_compared;
  int   n_mismatched;
  logic [5:0] q[$];

  skyline_area_checker_if bus();

  skyline_area_checker #(.MAX_PTS(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_pt(input int x, input int y);
    q.push_back(6'(x));
    q.push_back(6'(y));
  endtask

  // Drives queued words on consecutive cycles; returns #1 after the edge that took the last word.
  task automatic send_queue();
    while (q.size() > 0) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = q.pop_front();
      @(posedge CLK); #1;
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %0d expected 0", bus.RES_VALID); end
    if (bus.AREA !== 12'd0) begin n_mismatched++; $display("[TB] FAIL reset_area: got %0d expected 0", bus.AREA); end
    if (bus.NPTS !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_npts: got %0d expected 0", bus.NPTS); end
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %0d expected 0", bus.ERR); end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_nominal();
    bus.RES_READY = 1'b1;
    push_pt(2, 10); push_pt(3, 15); push_pt(7, 12); push_pt(12, 0);
    push_pt(15, 10); push_pt(20, 8); push_pt(24, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL nominal_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd212) begin n_mismatched++; $display("[TB] FAIL nominal_area: got %0d expected 212", bus.AREA); end
    if (bus.NPTS !== 5'd7) begin n_mismatched++; $display("[TB] FAIL nominal_npts: got %0d expected 7", bus.NPTS); end
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL nominal_err: got %0d expected 0", bus.ERR); end
    @(posedge CLK); #1;
    n_compared++;
    if (bus.RES_VALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nominal_drop: got %0d expected 0", bus.RES_VALID); end
  endtask

  task automatic test_single_building();
    push_pt(5, 63); push_pt(63, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd3654) begin n_mismatched++; $display("[TB] FAIL single_area: got %0d expected 3654", bus.AREA); end
    if (bus.NPTS !== 5'd2) begin n_mismatched++; $display("[TB] FAIL single_npts: got %0d expected 2", bus.NPTS); end
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL single_err: got %0d expected 0", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  // (4,9)(4,3)(8,3): repeated x, repeated y, nonzero final y; (8-4)*3 is still a valid term.
  task automatic test_malformed();
    push_pt(4, 9); push_pt(4, 3); push_pt(8, 3);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL malformed_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd12) begin n_mismatched++; $display("[TB] FAIL malformed_area: got %0d expected 12", bus.AREA); end
    if (bus.NPTS !== 5'd3) begin n_mismatched++; $display("[TB] FAIL malformed_npts: got %0d expected 3", bus.NPTS); end
    if (bus.ERR !== 5'b00111) begin n_mismatched++; $display("[TB] FAIL malformed_err: got %b expected 00111", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  task automatic test_odd_length();
    q.push_back(6'd3); q.push_back(6'd7); q.push_back(6'd9);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL odd_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd0) begin n_mismatched++; $display("[TB] FAIL odd_area: got %0d expected 0", bus.AREA); end
    if (bus.NPTS !== 5'd1) begin n_mismatched++; $display("[TB] FAIL odd_npts: got %0d expected 1", bus.NPTS); end
    if (bus.ERR !== 5'b00100) begin n_mismatched++; $display("[TB] FAIL odd_err: got %b expected 00100", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  // Unit-width steps with y alternating 1,2 and a final y of 0; count 16 is at the limit.
  task automatic test_npts_limits();
    int          n_tab[3]    = '{16, 17, 32};
    logic [11:0] area_tab[3] = '{12'd22, 12'd24, 12'd46};
    logic [4:0]  npts_tab[3] = '{5'd16, 5'd17, 5'd31};
    logic [4:0]  err_tab[3]  = '{5'b00000, 5'b10000, 5'b10000};
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < n_tab[c]; i++)
        push_pt(i + 1, (i == n_tab[c] - 1) ? 0 : ((i % 2 == 0) ? 1 : 2));
      send_queue();
      @(posedge CLK); #1;
      n_compared += 4;
      if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL npts%0d_valid: got %0d expected 1", n_tab[c], bus.RES_VALID); end
      if (bus.AREA !== area_tab[c]) begin n_mismatched++; $display("[TB] FAIL npts%0d_area: got %0d expected %0d", n_tab[c], bus.AREA, area_tab[c]); end
      if (bus.NPTS !== npts_tab[c]) begin n_mismatched++; $display("[TB] FAIL npts%0d_npts: got %0d expected %0d", n_tab[c], bus.NPTS, npts_tab[c]); end
      if (bus.ERR !== err_tab[c]) begin n_mismatched++; $display("[TB] FAIL npts%0d_err: got %b expected %b", n_tab[c], bus.ERR, err_tab[c]); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] hold_data[4] = '{6'd1, 6'd1, 6'd2, 6'd0};
    bus.RES_READY = 1'b0;
    push_pt(1, 2); push_pt(3, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 2;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd4) begin n_mismatched++; $display("[TB] FAIL bp_area: got %0d expected 4", bus.AREA); end
    for (int c = 0; c < 10; c++) begin
      bus.IN_VALID = (c < 4);
      bus.IN_DATA  = (c < 4) ? hold_data[c] : 6'd0;
      @(posedge CLK); #1;
      n_compared += 3;
      if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_hold_valid c%0d: got %0d expected 1", c, bus.RES_VALID); end
      if (bus.AREA !== 12'd4) begin n_mismatched++; $display("[TB] FAIL bp_hold_area c%0d: got %0d expected 4", c, bus.AREA); end
      if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL bp_hold_err c%0d: got %0d expected 0", c, bus.ERR); end
    end
    bus.IN_VALID  = 1'b0;
    bus.RES_READY = 1'b1;
    @(posedge CLK); #1;
    n_compared++;
    if (bus.RES_VALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_accept: got %0d expected 0", bus.RES_VALID); end
    push_pt(1, 2); push_pt(3, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 3;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_next_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd4) begin n_mismatched++; $display("[TB] FAIL bp_next_area: got %0d expected 4", bus.AREA); end
    if (bus.ERR !== 5'b01000) begin n_mismatched++; $display("[TB] FAIL bp_next_err: got %b expected 01000", bus.ERR); end
    @(posedge CLK); #1;
    push_pt(1, 2); push_pt(3, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared++;
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL bp_cleared_err: got %b expected 00000", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  task automatic test_simultaneous();
    bus.RES_READY = 1'b0;
    push_pt(2, 5); push_pt(6, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 2;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sim_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd20) begin n_mismatched++; $display("[TB] FAIL sim_area: got %0d expected 20", bus.AREA); end
    bus.RES_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.IN_DATA   = 6'd9;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    n_compared++;
    if (bus.RES_VALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sim_accept: got %0d expected 0", bus.RES_VALID); end
    push_pt(1, 2); push_pt(3, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 3;
    if (bus.AREA !== 12'd4) begin n_mismatched++; $display("[TB] FAIL sim_next_area: got %0d expected 4", bus.AREA); end
    if (bus.NPTS !== 5'd2) begin n_mismatched++; $display("[TB] FAIL sim_next_npts: got %0d expected 2", bus.NPTS); end
    if (bus.ERR !== 5'b01000) begin n_mismatched++; $display("[TB] FAIL sim_next_err: got %b expected 01000", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    bus.RES_READY = 1'b1;
    push_pt(5, 63); push_pt(63, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared++;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_first_valid: got %0d expected 1", bus.RES_VALID); end
    @(posedge CLK); #1;
    push_pt(10, 7); push_pt(13, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd21) begin n_mismatched++; $display("[TB] FAIL b2b_area: got %0d expected 21", bus.AREA); end
    if (bus.NPTS !== 5'd2) begin n_mismatched++; $display("[TB] FAIL b2b_npts: got %0d expected 2", bus.NPTS); end
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL b2b_err: got %b expected 00000", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_frame();
    bus.RES_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.IN_DATA   = 6'd1;
    @(posedge CLK); #1;
    bus.IN_DATA = 6'd2;
    @(posedge CLK); #1;
    bus.IN_DATA = 6'd3;
    RESET       = 1'b1;
    @(posedge CLK); #1;
    RESET        = 1'b0;
    bus.IN_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      n_compared++;
      if (bus.RES_VALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_valid c%0d: got %0d expected 0", c, bus.RES_VALID); end
    end
    push_pt(1, 2); push_pt(3, 0);
    send_queue();
    @(posedge CLK); #1;
    n_compared += 4;
    if (bus.RES_VALID !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_next_valid: got %0d expected 1", bus.RES_VALID); end
    if (bus.AREA !== 12'd4) begin n_mismatched++; $display("[TB] FAIL rst_next_area: got %0d expected 4", bus.AREA); end
    if (bus.NPTS !== 5'd2) begin n_mismatched++; $display("[TB] FAIL rst_next_npts: got %0d expected 2", bus.NPTS); end
    if (bus.ERR !== 5'd0) begin n_mismatched++; $display("[TB] FAIL rst_next_err: got %b expected 00000", bus.ERR); end
    @(posedge CLK); #1;
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    RESET         = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 6'd0;
    bus.RES_READY = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_nominal();
    test_single_building();
    test_malformed();
    test_odd_length();
    test_npts_limits();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
